// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one fixed-latency memory between fetch and data ports,
//            data first with a starvation guard for fetch.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic                gnt_data_q, gnt_data_d;
  logic                we_q, we_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                data_wins;

  // Fetch overrides data only once data has won STARVE_MAX times in a row
  // while fetch was waiting.
  assign data_wins = d_req && !(i_req && (scnt_q == SCNT_MAX));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      scnt_q     <= '0;
      gnt_data_q <= 1'b0;
      we_q       <= 1'b0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scnt_q     <= scnt_d;
      gnt_data_q <= gnt_data_d;
      we_q       <= we_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scnt_d     = scnt_q;
    gnt_data_d = gnt_data_q;
    we_d       = we_q;
    en_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d    = WAIT;
          en_d       = 1'b1;
          cnt_d      = CNT_LOAD;
          gnt_data_d = data_wins;
          if (data_wins) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            if (!i_req)
              scnt_d = '0;
            else if (scnt_q != SCNT_MAX)
              scnt_d = scnt_q + SCNT_W'(1);
          end else begin
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            scnt_d  = '0;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          if (!we_q) begin
            if (gnt_data_q)
              d_rdata_d = m_rdata;
            else
              i_rdata_d = m_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_en    = en_q;
  assign m_we    = en_q & we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = (state_q == ACK) && !gnt_data_q;
  assign d_ack   = (state_q == ACK) && gnt_data_q;
  assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 2;
  localparam int TMO  = 200;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          busy;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Memory environment: data only valid on the cycle the arbiter should sample.
  logic [DW-1:0] env_mem [0:2047];
  logic [DW-1:0] ref_mem [0:2047];
  int            age;
  logic          rd_window;

  always @(posedge clock or negedge reset)
    if (!reset)          age <= 100;
    else if (m_en)       age <= 1;
    else if (age < 100)  age <= age + 1;

  always @(posedge clock)
    if (reset && m_en && m_we) env_mem[m_addr[12:2]] <= m_wdata;

  assign rd_window = (LAT == 1) ? m_en : (age == LAT - 1);
  assign m_rdata   = rd_window ? env_mem[m_addr[12:2]] : (32'hBAD0_0000 | 32'(cyc));

  // Scoreboard queues filled by the drivers, drained by the monitor.
  logic [DW-1:0] iq[$];
  logic [DW-1:0] dq[$];
  bit            gq_port[$];
  int            gq_cyc[$];
  bit            glog[$];
  logic [DW-1:0] last_rd = '0;

  // Reference model state: consecutive data grants while fetch is waiting.
  int            streak;
  bit            prev_i, prev_d, prev_we, prev_men, win_d, g_port;
  logic [AW-1:0] prev_ia, prev_da;
  logic [DW-1:0] prev_wd, i_hold, d_hold, e;
  int            g_cyc;

  always @(negedge clock) begin
    if (!reset) begin
      iq.delete(); dq.delete(); gq_port.delete(); gq_cyc.delete();
      streak = 0; prev_i = 0; prev_d = 0; prev_we = 0; prev_men = 0;
      prev_ia = '0; prev_da = '0; prev_wd = '0; i_hold = '0; d_hold = '0;
    end else begin
      if (m_en) begin
        chk("m_en_pulse", 64'(prev_men), 64'(0));
        chk("grant_had_req", 64'(prev_i | prev_d), 64'(1));
        win_d = prev_d && !(prev_i && streak == SMAX);
        if (win_d) streak = prev_i ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
        else       streak = 0;
        chk("m_addr", 64'(m_addr), 64'(win_d ? prev_da : prev_ia));
        chk("m_we", 64'(m_we), 64'(win_d & prev_we));
        if (win_d && prev_we) chk("m_wdata", 64'(m_wdata), 64'(prev_wd));
        gq_port.push_back(win_d);
        gq_cyc.push_back(cyc);
      end
      if (i_ack || d_ack) begin
        chk("ack_excl", 64'(i_ack & d_ack), 64'(0));
        chk("grants_pending", 64'(gq_port.size()), 64'(1));
        if (gq_port.size() != 0) begin
          g_port = gq_port.pop_front();
          g_cyc  = gq_cyc.pop_front();
          chk("ack_port", 64'(d_ack), 64'(g_port));
          chk("ack_latency", 64'(cyc - g_cyc), 64'(LAT));
        end
        glog.push_back(d_ack);
      end
      if (i_ack) begin
        if (iq.size() == 0) chk("i_ack_unexpected", 64'(iq.size()), 64'(1));
        else begin
          e = iq.pop_front();
          chk("i_rdata", 64'(i_rdata), 64'(e));
          i_hold = e;
          chk("d_rdata_held", 64'(d_rdata), 64'(d_hold));
        end
      end
      if (d_ack) begin
        if (dq.size() == 0) chk("d_ack_unexpected", 64'(dq.size()), 64'(1));
        else begin
          e = dq.pop_front();
          chk("d_rdata", 64'(d_rdata), 64'(e));
          d_hold = e;
          chk("i_rdata_held", 64'(i_rdata), 64'(i_hold));
        end
      end
      prev_men = m_en;  prev_i  = i_req;  prev_d  = d_req;  prev_we = d_we;
      prev_ia  = i_addr; prev_da = d_addr; prev_wd = d_wdata;
    end
  end

  task automatic run_fetch(input int n, input logic [AW-1:0] fixed, input bit rnd,
                           input int gmax, output int lat);
    logic [AW-1:0] a;
    int t0, g;
    bit got;
    lat = 0;
    @(posedge clock); #1;
    for (int k = 0; k < n; k++) begin
      a = rnd ? (AW'($urandom_range(0, 1023)) << 2) : fixed;
      iq.push_back(ref_mem[a[12:2]]);
      i_addr = a; i_req = 1'b1; t0 = cyc; got = 1'b0;
      for (int w = 0; w < TMO && !got; w++) begin
        @(negedge clock);
        got = i_ack;
      end
      if (!got) begin
        chk("i_ack_timeout", 64'(got), 64'(1));
        break;
      end
      lat = cyc - t0;
      @(posedge clock); #1;
      g = $urandom_range(0, gmax);
      if (k == n - 1 || g > 0) begin
        i_req = 1'b0;
        repeat (g) begin @(posedge clock); #1; end
      end
    end
    i_req = 1'b0;
  endtask

  task automatic run_data(input int n, input logic [AW-1:0] fixed, input bit fwe,
                          input logic [DW-1:0] fwd, input bit rnd, input int gmax,
                          output int lat);
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    bit we, got;
    int t0, g;
    lat = 0;
    @(posedge clock); #1;
    for (int k = 0; k < n; k++) begin
      a  = rnd ? (32'h1000 | (AW'($urandom_range(0, 1023)) << 2)) : fixed;
      we = rnd ? 1'($urandom_range(0, 1)) : fwe;
      wd = rnd ? DW'($urandom) : fwd;
      if (we) ref_mem[a[12:2]] = wd;
      else    last_rd = ref_mem[a[12:2]];
      dq.push_back(last_rd);
      d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1; t0 = cyc; got = 1'b0;
      for (int w = 0; w < TMO && !got; w++) begin
        @(negedge clock);
        got = d_ack;
      end
      if (!got) begin
        chk("d_ack_timeout", 64'(got), 64'(1));
        break;
      end
      lat = cyc - t0;
      @(posedge clock); #1;
      g = $urandom_range(0, gmax);
      if (k == n - 1 || g > 0) begin
        d_req = 1'b0;
        repeat (g) begin @(posedge clock); #1; end
      end
    end
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat_i, lat_d, men_cnt, busy_cnt, t0;
    bit got;
    bit exp4 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    for (int k = 0; k < 2048; k++) begin
      env_mem[k] = (32'(k) * 32'h9E37_79B9) ^ 32'h0F0F_1234;
      ref_mem[k] = env_mem[k];
    end
    env_mem[4]  = 32'hDEAD_BEEF; ref_mem[4]  = 32'hDEAD_BEEF;
    env_mem[16] = 32'h1234_5678; ref_mem[16] = 32'h1234_5678;

    // Reset state and quiet idle.
    repeat (2) @(posedge clock); #1;
    chk("rst_m_en", 64'(m_en), 64'(0));
    chk("rst_m_we", 64'(m_we), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_acks", 64'({i_ack, d_ack}), 64'(0));
    chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
    chk("rst_m_addr", 64'(m_addr), 64'(0));
    chk("rst_m_wdata", 64'(m_wdata), 64'(0));
    reset = 1'b1;
    men_cnt = 0; busy_cnt = 0;
    repeat (5) begin
      @(negedge clock);
      men_cnt += int'(m_en);
      busy_cnt += int'(busy);
    end
    chk("idle_m_en_count", 64'(men_cnt), 64'(0));
    chk("idle_busy_count", 64'(busy_cnt), 64'(0));

    // Single fetch.
    run_fetch(1, 32'h10, 1'b0, 0, lat_i);
    chk("t2_i_latency", 64'(lat_i), 64'(LAT + 1));

    // Simultaneous requests: data first, fetch right after.
    fork
      run_fetch(1, 32'h10, 1'b0, 0, lat_i);
      run_data(1, 32'h40, 1'b0, '0, 1'b0, 0, lat_d);
    join
    chk("t3_d_latency", 64'(lat_d), 64'(LAT + 1));
    chk("t3_i_latency", 64'(lat_i), 64'(2 * LAT + 3));

    // Both held: starvation guard interleaves fetch.
    glog.delete();
    fork
      run_fetch(2, 32'h10, 1'b0, 0, lat_i);
      run_data(4, '0, 1'b0, '0, 1'b1, 0, lat_d);
    join
    chk("t4_grant_count", 64'(glog.size()), 64'(6));
    for (int k = 0; k < 6 && k < glog.size(); k++)
      chk($sformatf("t4_grant%0d_is_data", k), 64'(glog[k]), 64'(exp4[k]));

    // Write: same schedule, d_rdata held.
    run_data(1, 32'h80, 1'b1, 32'hA5A5_A5A5, 1'b0, 0, lat_d);
    chk("t5_d_latency", 64'(lat_d), 64'(LAT + 1));

    // Reset in the middle of a fetch.
    @(posedge clock); #1;
    i_addr = 32'h20; i_req = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("t6_m_en", 64'(m_en), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_i_ack", 64'(i_ack), 64'(0));
    chk("t6_m_addr", 64'(m_addr), 64'(0));
    repeat (2) @(posedge clock); #1;
    last_rd = '0;
    iq.push_back(ref_mem[8]);
    reset = 1'b1; t0 = cyc; got = 1'b0;
    for (int w = 0; w < TMO && !got; w++) begin
      @(negedge clock);
      got = i_ack;
    end
    chk("t6_ack_seen", 64'(got), 64'(1));
    chk("t6_i_latency", 64'(cyc - t0), 64'(LAT + 1));
    @(posedge clock); #1;
    i_req = 1'b0;

    // Randomized traffic from both ports.
    fork
      run_fetch(25, '0, 1'b1, 3, lat_i);
      run_data(35, '0, 1'b0, '0, 1'b1, 3, lat_d);
    join
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("iq_drained", 64'(iq.size()), 64'(0));
    chk("dq_drained", 64'(dq.size()), 64'(0));
    chk("gq_drained", 64'(gq_port.size()), 64'(0));
    chk("end_busy", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
